// File: rtl/cia_sp_peer_if.sv
// Local-side byte interface of the CIA SP/CNT peer.
//
// Handshake: a TX byte transfers on a rising clk edge where tx_valid and
// tx_ready are both 1. tx_data must stay stable while tx_valid is high, and
// tx_valid may not be withdrawn until the transfer happens. tx_ready depends
// only on FIFO state, never on tx_valid. RX has no back-pressure:
// rx_valid/rx_err/tx_done are single-cycle pulses and rx_data holds until
// the next completed byte.
interface cia_sp_peer_if #(
  parameter int TX_DEPTH = 4
);
  localparam int LW = $clog2(TX_DEPTH) + 1;

  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_err;
  logic          tx_done;
  logic          busy;
  logic [LW-1:0] tx_level;

  // Local logic that feeds and drains the peer.
  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_err, tx_done, busy, tx_level
  );

  // The peer itself.
  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_err, tx_done, busy, tx_level
  );
endinterface

// File: rtl/cia_sp_peer.sv
// Far-end partner for the CIA SP/CNT serial port. Receives bytes clocked by
// the host on CNT, and transmits queued bytes by generating CNT/SP itself
// once the line has been quiet for IDLE_GAP cycles.
module cia_sp_peer #(
  parameter int HALF_PERIOD    = 8,
  parameter int TX_DEPTH       = 4,
  parameter int IDLE_GAP       = 16,
  parameter int RX_TIMEOUT     = 4096,
  parameter int RX_SAMPLE_FALL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cnt_in,
  input  logic         sp_in,
  output logic         cnt_out,
  output logic         sp_out,
  cia_sp_peer_if.slave bus,
  output logic [2:0]   dbg_state_o
);

  localparam int PW   = $clog2(TX_DEPTH);
  localparam int LW   = PW + 1;
  localparam int TMAX = (HALF_PERIOD > IDLE_GAP) ? HALF_PERIOD : IDLE_GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int OW   = $clog2(RX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_GAP = 3'd1,
    S_LOW      = 3'd2,
    S_HIGH     = 3'd3,
    S_POST     = 3'd4
  } state_e;

  // ---------------------------------------------------------------- sync
  logic cnt_s1_q, cnt_s2_q, cnt_prev_q, sp_s1_q, sp_s2_q;
  logic cnt_fall, cnt_rise;

  // Two-flop synchronisers plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_s1_q   <= 1'b1;
      cnt_s2_q   <= 1'b1;
      cnt_prev_q <= 1'b1;
      sp_s1_q    <= 1'b1;
      sp_s2_q    <= 1'b1;
    end else begin
      cnt_s1_q   <= cnt_in;
      cnt_s2_q   <= cnt_s1_q;
      cnt_prev_q <= cnt_s2_q;
      sp_s1_q    <= sp_in;
      sp_s2_q    <= sp_s1_q;
    end
  end

  assign cnt_fall = cnt_prev_q & ~cnt_s2_q;
  assign cnt_rise = ~cnt_prev_q & cnt_s2_q;

  // ------------------------------------------------------------------ RX
  state_e          state_q, state_d;
  logic [7:0]      rx_sh_q;
  logic [2:0]      rx_bits_q;
  logic            rx_load_q;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q;
  logic            rx_err_q;
  logic [OW-1:0]   tmo_q;
  logic            rx_active, rx_edge, rx_shift, rx_tmo_hit;

  // Our own CNT edges while transmitting must not be taken as host data.
  assign rx_active  = (state_q == S_IDLE) || (state_q == S_WAIT_GAP);
  assign rx_edge    = (RX_SAMPLE_FALL != 0) ? cnt_fall : cnt_rise;
  assign rx_shift   = rx_active & rx_edge;
  assign rx_tmo_hit = (rx_bits_q != 3'd0) && (tmo_q == OW'(RX_TIMEOUT));

  // RX shifter, byte completion and partial-byte timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sh_q    <= 8'h00;
      rx_bits_q  <= 3'd0;
      rx_load_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      tmo_q      <= '0;
    end else begin
      rx_valid_q <= rx_load_q;
      rx_load_q  <= 1'b0;
      rx_err_q   <= 1'b0;
      if (rx_load_q) rx_data_q <= rx_sh_q;
      if (cnt_fall | cnt_rise) tmo_q <= '0;
      else if (tmo_q != OW'(RX_TIMEOUT)) tmo_q <= tmo_q + OW'(1);
      if (rx_shift) begin
        rx_sh_q   <= {rx_sh_q[6:0], sp_s2_q};
        rx_bits_q <= rx_bits_q + 3'd1;
        if (rx_bits_q == 3'd7) rx_load_q <= 1'b1;
      end else if (rx_tmo_hit) begin
        rx_bits_q <= 3'd0;
        rx_err_q  <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------- TX FIFO
  logic [7:0]    mem_q [TX_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [LW-1:0] fcnt_q;
  logic          push, pop, tx_ready;
  logic [7:0]    head;

  assign tx_ready = (fcnt_q != LW'(TX_DEPTH));
  assign push     = bus.tx_valid & tx_ready;
  assign head     = mem_q[rd_q];

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.tx_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + LW'(1);
        2'b01:   fcnt_q <= fcnt_q - LW'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // -------------------------------------------------------------- TX FSM
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bidx_q, bidx_d, bidx_m1;
  logic [2:0]    col_q, col_d;
  logic [7:0]    sh_q;
  logic          sp_q, sp_d;
  logic          tx_done_q, tx_done_d;
  logic          gap_ok;

  assign gap_ok  = cnt_s2_q && (rx_bits_q == 3'd0);
  assign bidx_m1 = bidx_q - 3'd1;

  // FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      bidx_q    <= 3'd0;
      col_q     <= 3'd0;
      sh_q      <= 8'h00;
      sp_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bidx_q    <= bidx_d;
      col_q     <= col_d;
      sp_q      <= sp_d;
      tx_done_q <= tx_done_d;
      if (pop) sh_q <= head;
    end
  end

  // Next state: gap wait, half-period phases, collision abort, post gap.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bidx_d    = bidx_q;
    col_d     = 3'd0;
    sp_d      = sp_q;
    tx_done_d = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        sp_d  = 1'b1;
        tmr_d = '0;
        if (fcnt_q != '0) state_d = S_WAIT_GAP;
      end
      S_WAIT_GAP: begin
        if (!gap_ok) begin
          tmr_d = '0;
        end else if (tmr_q == TW'(IDLE_GAP - 1)) begin
          pop     = 1'b1;
          tmr_d   = '0;
          bidx_d  = 3'd7;
          sp_d    = head[7];
          state_d = S_LOW;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_LOW: begin
        if (tmr_q == TW'(HALF_PERIOD - 1)) begin
          tmr_d   = '0;
          state_d = S_HIGH;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_HIGH: begin
        // The synced line lags our own release by two cycles, so only a
        // run of four low samples means another driver holds CNT.
        if (!cnt_s2_q) col_d = col_q + 3'd1;
        if (!cnt_s2_q && (col_q == 3'd3)) begin
          col_d   = 3'd0;
          tmr_d   = '0;
          sp_d    = 1'b1;
          state_d = S_POST;
        end else if (tmr_q == TW'(HALF_PERIOD - 1)) begin
          tmr_d = '0;
          col_d = 3'd0;
          if (bidx_q == 3'd0) begin
            tx_done_d = 1'b1;
            sp_d      = 1'b1;
            state_d   = S_POST;
          end else begin
            bidx_d  = bidx_m1;
            sp_d    = sh_q[bidx_m1];
            state_d = S_LOW;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_POST: begin
        if (tmr_q == TW'(IDLE_GAP - 1)) begin
          tmr_d   = '0;
          state_d = (fcnt_q != '0) ? S_WAIT_GAP : S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------- outputs
  assign cnt_out      = (state_q != S_LOW);
  assign sp_out       = sp_q;
  assign dbg_state_o  = state_q;
  assign bus.tx_ready = tx_ready;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_err   = rx_err_q;
  assign bus.tx_done  = tx_done_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.tx_level = fcnt_q;

endmodule

// File: tb/tb_cia_sp_peer.sv
// Bench for cia_sp_peer: host side of the CNT/SP wires, RX frame table,
// directed TX/abort/reset sequences and randomized traffic.
module tb_cia_sp_peer;
  localparam int HP    = 8;
  localparam int DEPTH = 4;
  localparam int GAP   = 16;
  localparam int TMO   = 4096;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_LOW  = 3'd2;
  localparam logic [2:0] ST_HIGH = 3'd3;
  localparam logic [2:0] ST_POST = 3'd4;

  // ---------------------------------------------------- clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       host_cnt, host_sp;
  logic       cnt_out, sp_out, cnt_in, sp_in;
  logic [2:0] dbg_state;

  // Open-collector wires: low wins.
  assign cnt_in = cnt_out & host_cnt;
  assign sp_in  = sp_out & host_sp;

  cia_sp_peer_if #(.TX_DEPTH(DEPTH)) bus ();

  cia_sp_peer #(
    .HALF_PERIOD(HP), .TX_DEPTH(DEPTH), .IDLE_GAP(GAP),
    .RX_TIMEOUT(TMO), .RX_SAMPLE_FALL(1)
  ) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .sp_in(sp_in),
    .cnt_out(cnt_out), .sp_out(sp_out), .bus(bus), .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------- scoreboard
  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Event counters.
  int rxv_cnt = 0, rxe_cnt = 0, n_done = 0;
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) rxv_cnt++;
    if (bus.rx_err === 1'b1)   rxe_cnt++;
    if (bus.tx_done === 1'b1)  n_done++;
  end

  // Host CIA in input mode: samples SP on each CNT rise.
  bit         host_rx_en = 0;
  int         host_bits  = 0;
  logic [7:0] host_sh    = 8'h00;
  logic       host_prev  = 1'b1;
  always @(negedge clk) begin
    if (host_rx_en && cnt_in === 1'b1 && host_prev === 1'b0) begin
      host_sh = {host_sh[6:0], sp_in};
      host_bits++;
      if (host_bits == 8) begin
        host_bits = 0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL tx_unexpected_byte: got %0h expected none", host_sh);
        end else begin
          check("tx_byte", 32'(host_sh), 32'(exp_q.pop_front()));
        end
      end
    end
    host_prev = cnt_in;
  end

  // CNT shape: low phases of HP cycles, high runs either HP or >= GAP.
  bit chk_line  = 0;
  bit seen_rise = 0;
  int low_len = 0, high_len = 0;
  logic prev_co = 1'b1;
  always @(negedge clk) begin
    if (cnt_out === 1'b0) begin
      if (prev_co === 1'b1 && chk_line && seen_rise)
        check("hi_run_len", 32'(high_len == HP || high_len >= GAP), 32'd1);
      low_len++;
      high_len = 0;
    end else if (cnt_out === 1'b1) begin
      if (prev_co === 1'b0) begin
        if (chk_line) check("lo_run_len", 32'(low_len), 32'(HP));
        seen_rise = 1;
      end
      high_len++;
      low_len = 0;
    end
    prev_co = cnt_out;
  end

  // ---------------------------------------------------------- drivers
  task automatic push_byte(input logic [7:0] b, input int budget, output bit ok);
    int c;
    c  = 0;
    ok = 0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (!ok && c < budget) begin
      if (bus.tx_ready === 1'b1) ok = 1;
      @(negedge clk);
      c++;
    end
    bus.tx_valid = 1'b0;
    if (ok) exp_q.push_back(b);
    check("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic host_frame(input int nbits, input logic [7:0] d);
    for (int i = 0; i < nbits; i++) begin
      host_sp = d[7-i];
      repeat (5) @(negedge clk);
      host_cnt = 1'b0;
      repeat (10) @(negedge clk);
      host_cnt = 1'b1;
      repeat (5) @(negedge clk);
    end
    host_sp = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (!(bus.busy === 1'b0 && bus.tx_level === '0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("idle_reached", 32'(c < budget), 32'd1);
  endtask

  // RX frame table.
  typedef struct {
    int         nbits;
    logic [7:0] data;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } rx_vec_t;

  rx_vec_t rx_tab[6];

  // Watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------- test
  initial begin
    bit ok;
    int v0, e0, d0, c, n, nl, n_wait, first_low, done_cyc, n_low;
    bit seen_post;
    logic [7:0] sp_seq, b;
    logic pc;

    rx_tab[0] = '{8, 8'hA5, 1, 0, 8'hA5};
    rx_tab[1] = '{3, 8'hE0, 0, 1, 8'hA5};
    rx_tab[2] = '{8, 8'h01, 1, 0, 8'h01};
    rx_tab[3] = '{8, 8'hFF, 1, 0, 8'hFF};
    rx_tab[4] = '{8, 8'h00, 1, 0, 8'h00};
    rx_tab[5] = '{8, 8'h5A, 1, 0, 8'h5A};

    reset        = 1'b1;
    host_cnt     = 1'b1;
    host_sp      = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_cnt_out",  32'(cnt_out), 32'd1);
    check("rst_sp_out",   32'(sp_out), 32'd1);
    check("rst_rx_data",  32'(bus.rx_data), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_err",   32'(bus.rx_err), 32'd0);
    check("rst_tx_done",  32'(bus.tx_done), 32'd0);
    check("rst_busy",     32'(bus.busy), 32'd0);
    check("rst_level",    32'(bus.tx_level), 32'd0);
    check("rst_ready",    32'(bus.tx_ready), 32'd1);
    check("rst_state",    32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // RX table: full bytes, a partial byte that times out, recovery.
    for (int i = 0; i < 6; i++) begin
      v0 = rxv_cnt;
      e0 = rxe_cnt;
      host_frame(rx_tab[i].nbits, rx_tab[i].data);
      repeat ((rx_tab[i].exp_err != 0) ? TMO + 50 : 10) @(negedge clk);
      check("rx_valid_cnt", 32'(rxv_cnt - v0), 32'(rx_tab[i].exp_valid));
      check("rx_err_cnt",   32'(rxe_cnt - e0), 32'(rx_tab[i].exp_err));
      check("rx_data",      32'(bus.rx_data), 32'(rx_tab[i].exp_data));
    end

    // Single byte 0x3C on an idle line.
    host_rx_en = 1;
    host_bits  = 0;
    chk_line   = 1;
    d0 = n_done;
    push_byte(8'h3C, 10, ok);
    n_wait = 0; first_low = -1; done_cyc = -1; n_low = 0; sp_seq = 8'h00; pc = 1'b1;
    for (int cy = 0; cy < 400 && done_cyc < 0; cy++) begin
      if (dbg_state == ST_WAIT) n_wait++;
      if (cnt_out == 1'b0 && pc == 1'b1) begin
        if (first_low < 0) first_low = cy;
        n_low++;
        sp_seq = {sp_seq[6:0], sp_out};
      end
      pc = cnt_out;
      if (bus.tx_done == 1'b1) done_cyc = cy;
      @(negedge clk);
    end
    check("gap_cycles",    32'(n_wait), 32'(GAP));
    check("first_low_lat", 32'(first_low), 32'(GAP + 1));
    check("done_latency",  32'(done_cyc - first_low), 32'(16 * HP));
    check("low_pulses",    32'(n_low), 32'd8);
    check("sp_sequence",   32'(sp_seq), 32'h3C);
    check("sp_after_done", 32'(sp_out), 32'd1);
    wait_idle(500);
    check("tx_all_sent_1", 32'(exp_q.size()), 32'd0);
    check("tx_done_cnt_1", 32'(n_done - d0), 32'd1);

    // FIFO fill: four accepted back to back, fifth waits for the first pop.
    d0 = n_done;
    push_byte(8'h11, 10, ok);
    push_byte(8'h22, 10, ok);
    push_byte(8'h33, 10, ok);
    push_byte(8'h44, 10, ok);
    check("full_level", 32'(bus.tx_level), 32'(DEPTH));
    check("full_ready", 32'(bus.tx_ready), 32'd0);
    push_byte(8'h55, 100, ok);
    check("fifth_during_low", 32'(dbg_state), 32'(ST_LOW));
    check("fifth_level",      32'(bus.tx_level), 32'(DEPTH));
    wait_idle(3000);
    check("tx_all_sent_5", 32'(exp_q.size()), 32'd0);
    check("tx_done_cnt_5", 32'(n_done - d0), 32'd5);

    // Collision: host holds CNT low through a HIGH phase.
    push_byte(8'h96, 10, ok);
    push_byte(8'h69, 10, ok);
    c = 0;
    while (dbg_state !== ST_HIGH && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("reach_high", 32'(c < 500), 32'd1);
    d0 = n_done;
    seen_post = 0;
    host_cnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (dbg_state == ST_POST && !seen_post) begin
        seen_post = 1;
        check("abort_cnt_out", 32'(cnt_out), 32'd1);
        check("abort_sp_out",  32'(sp_out), 32'd1);
      end
    end
    host_cnt = 1'b1;
    check("abort_post", 32'(seen_post), 32'd1);
    void'(exp_q.pop_front());
    repeat (3) @(negedge clk);
    host_bits = 0;
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    wait_idle(1000);
    check("abort_next_sent", 32'(exp_q.size()), 32'd0);
    check("abort_done_cnt",  32'(n_done - d0), 32'd1);

    // Reset during bit 4 with a second byte still queued.
    push_byte(8'hC3, 10, ok);
    push_byte(8'hE7, 10, ok);
    nl = 0; pc = cnt_out; c = 0;
    while (nl < 4 && c < 1000) begin
      @(negedge clk);
      c++;
      if (cnt_out == 1'b0 && pc == 1'b1) nl++;
      pc = cnt_out;
    end
    check("reach_bit4", 32'(nl), 32'd4);
    check("pre_rst_level", 32'(bus.tx_level), 32'd1);
    chk_line = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_cnt_out", 32'(cnt_out), 32'd1);
    check("mid_rst_sp_out",  32'(sp_out), 32'd1);
    check("mid_rst_busy",    32'(bus.busy), 32'd0);
    check("mid_rst_level",   32'(bus.tx_level), 32'd0);
    check("mid_rst_ready",   32'(bus.tx_ready), 32'd1);
    reset = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    host_bits = 0;
    seen_rise = 0;
    chk_line  = 1;

    // Randomized traffic in both directions.
    for (int r = 0; r < 8; r++) begin
      host_rx_en = 1;
      host_bits  = 0;
      d0 = n_done;
      n  = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom_range(0, 255));
        repeat ($urandom_range(0, 30)) @(negedge clk);
        push_byte(b, 2000, ok);
      end
      wait_idle(4000);
      check("rnd_tx_sent", 32'(exp_q.size()), 32'd0);
      check("rnd_tx_done", 32'(n_done - d0), 32'(n));
      host_rx_en = 0;
      repeat (5) @(negedge clk);
      b  = 8'($urandom_range(0, 255));
      v0 = rxv_cnt;
      host_frame(8, b);
      repeat (10) @(negedge clk);
      check("rnd_rx_valid", 32'(rxv_cnt - v0), 32'd1);
      check("rnd_rx_data",  32'(bus.rx_data), 32'(b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/cia_sp_peer.md
Name: cia_sp_peer

Overview:
Serial-port partner device for the CIA SP/CNT interface. It sits on the far end of the CNT/SP wires and does two things:
- Receives bytes when the host CIA shifts data out (host drives CNT).
- Transmits bytes to a host CIA in input mode, with this block generating CNT and SP.
It is used by peripheral cores (fast-serial drive, keyboard/link emulation) and exposes byte-level valid/ready handshakes to local logic.

Parameters:
HALF_PERIOD, 8, clk cycles per CNT low phase and per CNT high phase when transmitting (minimum 2)
TX_DEPTH, 4, TX FIFO entries (power of two, 2..16)
IDLE_GAP, 16, clk cycles CNT must be seen high and RX idle before TX may start a byte
RX_TIMEOUT, 4096, clk cycles without a CNT edge after which a partial RX byte is discarded
RX_SAMPLE_FALL, 1, 1 = sample SP on CNT falling edge; 0 = sample on rising edge

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cnt_in  in  1  CNT line as seen on the wire (wired-AND of all drivers)
sp_in  in  1  SP line as seen on the wire
cnt_out  out  1  CNT drive, open-collector style (1 = released)
sp_out  out  1  SP drive (1 = released)
tx_data  in  8  byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  FIFO not full; a byte is accepted when tx_valid & tx_ready
rx_data  out  8  last received byte, held until the next byte completes
rx_valid  out  1  one-cycle pulse, rx_data updated
rx_err  out  1  one-cycle pulse, partial byte discarded on timeout
tx_done  out  1  one-cycle pulse after the 8th CNT rising edge of a transmitted byte
busy  out  1  TX FSM not in IDLE
tx_level  out  $clog2(TX_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: cnt_out=1, sp_out=1, rx_data=0, rx_valid=0, rx_err=0, tx_done=0, busy=0, FIFO empty (tx_level=0), tx_ready=1, RX bit count 0, TX FSM IDLE.
- Input sync: cnt_in and sp_in each pass through 2 flops. Edges are detected on the synced CNT versus its previous value. Input-to-detection latency is 3 clk.
- RX (active only while the TX FSM is in IDLE or WAIT_GAP):
  - On the selected CNT edge, shift the synced SP in MSB first and increment a 3-bit count.
  - On the 8th shift: rx_data is loaded with the full byte on the next cycle, rx_valid pulses together with that update, and the count wraps to 0.
  - A timeout counter resets on every CNT edge. If the count is nonzero and the timeout counter reaches RX_TIMEOUT: count is cleared, rx_err pulses, rx_data is unchanged.
  - CNT edges that occur while TX is active are self-generated and are ignored by RX.
- TX FIFO:
  - Push on tx_valid & tx_ready.
  - Pop when the FSM leaves WAIT_GAP.
  - Simultaneous push and pop in the same cycle while full is not possible (tx_ready=0); push and pop in the same cycle otherwise keeps tx_level unchanged.
  - Pointers wrap modulo TX_DEPTH.
- TX FSM:
  - IDLE: moves to WAIT_GAP when the FIFO is non-empty.
  - WAIT_GAP: a gap counter counts cycles with synced CNT=1 and RX count=0. It clears whenever synced CNT=0 or RX count≠0. When it reaches IDLE_GAP: pop the byte into the shifter, bit index 7, go to LOW.
  - LOW: cnt_out=0; sp_out=current bit on the first LOW cycle; hold for HALF_PERIOD cycles, then go to HIGH.
  - HIGH: cnt_out=1 for HALF_PERIOD cycles. If bit index 0: pulse tx_done, sp_out=1, go to POST. Otherwise decrement the index and go to LOW.
  - POST: hold cnt_out=1 for IDLE_GAP cycles. Then go to WAIT_GAP if the FIFO is non-empty, else IDLE.
  - Byte duration: 16*HALF_PERIOD cycles from LOW entry to POST entry.
- Collision: if synced CNT=0 during HIGH for more than 3 consecutive cycles (another driver is pulling CNT low), abort. On abort: cnt_out=1, sp_out=1, the byte is dropped without tx_done, and the FSM goes to POST.
- Reset mid-byte: all lines are released the same cycle reset is sampled, and the FIFO contents are discarded.

Test Plan:
- RX_SAMPLE_FALL=1: drive 8 CNT pulses (period 20 clk) with SP presenting 0xA5 MSB first, stable across each falling edge -> single rx_valid pulse, rx_data=0xA5, rx_err=0.
- Push 0x3C with HALF_PERIOD=8 and the line idle -> WAIT_GAP holds 16 clk, then cnt_out shows 8 low/high pulses of 8 clk each, sp_out sequence 0,0,1,1,1,1,0,0, tx_done 128 clk after the first LOW cycle, sp_out=1 afterwards.
- Push 5 bytes with TX_DEPTH=4 -> tx_ready=0 after the 4th accept; the 5th is accepted after the first pop; all 5 are sent in order with ≥IDLE_GAP high between bytes.
- 3 CNT edges then silence for RX_TIMEOUT -> rx_err pulses once, no rx_valid; a following full byte 0x01 -> rx_valid, rx_data=0x01.
- Force cnt_in=0 for 5 cycles during a HIGH phase -> abort: cnt_out=sp_out=1, no tx_done, FSM reaches POST, and the next FIFO byte is sent afterwards.
- Assert reset during bit 4 of a byte -> next cycle cnt_out=1, sp_out=1, busy=0, tx_level=0, tx_ready=1.
